// File: rtl/seq_alu.sv
// seq_alu: multi-cycle integer ALU with valid/ready handshakes on both sides.
// Ports: clk, rst_n (sync, active-low), ena (global freeze),
//        in_valid/in_ready + op/a/b request, out_valid/out_ready + result/flags response.
//        flags = {dz, ov, cout, zero}; result is 2*WIDTH bits.
module seq_alu #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic [3:0]         flags
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, MUL = 3'd2, DIV = 3'd3,
                         MOD = 3'd4, AND = 3'd5, OR = 3'd6, XOR = 3'd7;
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  state_t state;
  logic [2:0] op_r;
  logic [WIDTH-1:0] a_r, b_r, hi, lo, hi_n, lo_n, r1_lo;
  logic [CW-1:0] cnt;
  logic [WIDTH:0] sum, dif, msum, shf;
  logic [2*WIDTH-1:0] r1, xres;
  logic ge, bz, divop, dz1, c1, v1, go_exec;
  assign in_ready = state == IDLE;
  // One iteration step. MUL: hi accumulates, lo holds the multiplier and
  // collects product bits as they shift out. DIV/MOD: hi is the partial
  // remainder, lo starts as the dividend and fills with quotient bits.
  always_comb begin
    msum = {1'b0, hi} + (lo[0] ? {1'b0, a_r} : {(WIDTH+1){1'b0}});
    shf  = {hi, lo[WIDTH-1]};
    ge   = shf >= {1'b0, b_r};
    hi_n = (op_r == MUL) ? msum[WIDTH:1] : ge ? WIDTH'(shf - {1'b0, b_r}) : shf[WIDTH-1:0];
    lo_n = (op_r == MUL) ? {msum[0], lo[WIDTH-1:1]} : {lo[WIDTH-2:0], ge};
    xres = (op_r == MUL) ? {hi_n, lo_n} : {{WIDTH{1'b0}}, (op_r == DIV) ? lo_n : hi_n};
  end
  // Single-cycle results, computed straight from the request inputs.
  always_comb begin
    sum   = {1'b0, a} + {1'b0, b};
    dif   = {1'b0, a} - {1'b0, b};
    bz    = b == '0;
    divop = (op == DIV) || (op == MOD);
    dz1   = divop && bz;
    go_exec = (op == MUL) || (divop && !bz);
    r1_lo = (op == ADD) ? sum[WIDTH-1:0] :
            (op == SUB) ? dif[WIDTH-1:0] :
            (op == AND) ? (a & b) :
            (op == OR)  ? (a | b) :
            (op == XOR) ? (a ^ b) :
            (op == DIV) ? {WIDTH{1'b1}} : a;
    r1 = {{WIDTH{1'b0}}, r1_lo};
    c1 = (op == ADD) ? sum[WIDTH] : (op == SUB) && dif[WIDTH];
    v1 = (op == ADD) ? (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]) :
         (op == SUB) && (a[WIDTH-1] != b[WIDTH-1]) && (dif[WIDTH-1] != a[WIDTH-1]);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      op_r      <= '0;
      a_r       <= '0;
      b_r       <= '0;
      hi        <= '0;
      lo        <= '0;
      cnt       <= '0;
      result    <= '0;
      flags     <= '0;
      out_valid <= 1'b0;
    end else if (ena) begin
      case (state)
        IDLE: if (in_valid) begin
          op_r <= op;
          a_r  <= a;
          b_r  <= b;
          hi   <= '0;
          lo   <= (op == MUL) ? b : a;
          cnt  <= '0;
          if (go_exec) state <= EXEC;
          else begin
            state     <= DONE;
            result    <= r1;
            flags     <= {dz1, v1, c1, r1 == '0};
            out_valid <= 1'b1;
          end
        end
        EXEC: begin
          hi  <= hi_n;
          lo  <= lo_n;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            state     <= DONE;
            result    <= xres;
            flags     <= {3'b000, xres == '0};
            out_valid <= 1'b1;
          end
        end
        DONE: if (out_ready) begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed self-checking bench for seq_alu at WIDTH=8.
module tb_seq_alu;
  logic clk = 1'b0;
  logic rst_n, ena, in_valid, in_ready, out_valid, out_ready;
  logic [2:0] op;
  logic [7:0] a, b;
  logic [15:0] result;
  logic [3:0] flags;
  int vectors = 0, errs = 0, lat;
  logic saw_ready;
  always #5 clk = ~clk;
  seq_alu #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flags(flags)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  // Present one request for a single edge, then wait (bounded) for out_valid.
  task automatic issue(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
    op = o; a = x; b = y; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    lat = 1;
    saw_ready = 1'b0;
    while (!out_valid && lat < 40) begin
      saw_ready |= in_ready;
      tick;
      lat++;
    end
  endtask
  task automatic drain;
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
  endtask
  task automatic test_reset;
    vectors++; if (out_valid !== 1'b0) begin errs++; $display("FAIL reset out_valid got %b want 0", out_valid); end
    vectors++; if (in_ready !== 1'b1) begin errs++; $display("FAIL reset in_ready got %b want 1", in_ready); end
    vectors++; if (result !== 16'h0000) begin errs++; $display("FAIL reset result got %h want 0000", result); end
    vectors++; if (flags !== 4'b0000) begin errs++; $display("FAIL reset flags got %b want 0000", flags); end
  endtask
  task automatic test_single_cycle;
    logic [2:0]  ops [3] = '{3'd0, 3'd1, 3'd7};
    logic [7:0]  xs  [3] = '{8'd200, 8'h80, 8'h5A};
    logic [7:0]  ys  [3] = '{8'd100, 8'h01, 8'h5A};
    logic [15:0] er  [3] = '{16'h002C, 16'h007F, 16'h0000};
    logic [3:0]  ef  [3] = '{4'b0010, 4'b0100, 4'b0001};
    for (int i = 0; i < 3; i++) begin
      issue(ops[i], xs[i], ys[i]);
      vectors++; if (lat !== 1) begin errs++; $display("FAIL single[%0d] latency got %0d want 1", i, lat); end
      vectors++; if (result !== er[i]) begin errs++; $display("FAIL single[%0d] result got %h want %h", i, result, er[i]); end
      vectors++; if (flags !== ef[i]) begin errs++; $display("FAIL single[%0d] flags got %b want %b", i, flags, ef[i]); end
      drain;
    end
  endtask
  task automatic test_mul;
    issue(3'd2, 8'd255, 8'd255);
    vectors++; if (lat !== 9) begin errs++; $display("FAIL mul latency got %0d want 9", lat); end
    vectors++; if (result !== 16'hFE01) begin errs++; $display("FAIL mul result got %h want FE01", result); end
    vectors++; if (flags !== 4'b0000) begin errs++; $display("FAIL mul flags got %b want 0000", flags); end
    vectors++; if (saw_ready !== 1'b0) begin errs++; $display("FAIL mul in_ready got %b want 0 during exec", saw_ready); end
    drain;
    issue(3'd2, 8'd13, 8'd11);
    vectors++; if (result !== 16'h008F) begin errs++; $display("FAIL mul2 result got %h want 008F", result); end
    drain;
  endtask
  task automatic test_divide;
    logic [2:0]  ops [5] = '{3'd3, 3'd4, 3'd3, 3'd4, 3'd3};
    logic [7:0]  xs  [5] = '{8'd200, 8'd200, 8'd5, 8'd5, 8'd3};
    logic [7:0]  ys  [5] = '{8'd7, 8'd7, 8'd0, 8'd0, 8'd10};
    logic [15:0] er  [5] = '{16'h001C, 16'h0004, 16'h00FF, 16'h0005, 16'h0000};
    logic [3:0]  ef  [5] = '{4'b0000, 4'b0000, 4'b1000, 4'b1000, 4'b0001};
    int          el  [5] = '{9, 9, 1, 1, 9};
    for (int i = 0; i < 5; i++) begin
      issue(ops[i], xs[i], ys[i]);
      vectors++; if (lat !== el[i]) begin errs++; $display("FAIL div[%0d] latency got %0d want %0d", i, lat, el[i]); end
      vectors++; if (result !== er[i]) begin errs++; $display("FAIL div[%0d] result got %h want %h", i, result, er[i]); end
      vectors++; if (flags !== ef[i]) begin errs++; $display("FAIL div[%0d] flags got %b want %b", i, flags, ef[i]); end
      drain;
    end
  endtask
  task automatic test_back_to_back;
    issue(3'd0, 8'd1, 8'd1);
    op = 3'd0; a = 8'd7; b = 8'd7; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) tick;
    vectors++; if (result !== 16'h0002) begin errs++; $display("FAIL bp result got %h want 0002", result); end
    vectors++; if (in_ready !== 1'b0) begin errs++; $display("FAIL bp in_ready got %b want 0", in_ready); end
    vectors++; if (out_valid !== 1'b1) begin errs++; $display("FAIL bp out_valid got %b want 1", out_valid); end
    drain;
    vectors++; if (out_valid !== 1'b0) begin errs++; $display("FAIL bp handshake out_valid got %b want 0", out_valid); end
    vectors++; if (in_ready !== 1'b1) begin errs++; $display("FAIL bp handshake in_ready got %b want 1", in_ready); end
    tick;
    in_valid = 1'b0;
    vectors++; if (out_valid !== 1'b1) begin errs++; $display("FAIL bp next out_valid got %b want 1", out_valid); end
    vectors++; if (result !== 16'h000E) begin errs++; $display("FAIL bp next result got %h want 000E", result); end
    drain;
  endtask
  task automatic test_ena;
    ena = 1'b0; op = 3'd0; a = 8'd9; b = 8'd9; in_valid = 1'b1;
    tick;
    in_valid = 1'b0; ena = 1'b1;
    vectors++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errs++; $display("FAIL ena idle in_ready/out_valid got %b%b want 10", in_ready, out_valid); end
    op = 3'd3; a = 8'd250; b = 8'd3; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    lat = 1;
    for (int i = 0; i < 2; i++) begin tick; lat++; end
    ena = 1'b0;
    for (int i = 0; i < 3; i++) begin tick; lat++; end
    ena = 1'b1;
    while (!out_valid && lat < 40) begin tick; lat++; end
    vectors++; if (lat !== 12) begin errs++; $display("FAIL ena latency got %0d want 12", lat); end
    vectors++; if (result !== 16'h0053) begin errs++; $display("FAIL ena result got %h want 0053", result); end
    ena = 1'b0; out_ready = 1'b1;
    tick; tick;
    vectors++; if (out_valid !== 1'b1) begin errs++; $display("FAIL ena done out_valid got %b want 1", out_valid); end
    vectors++; if (result !== 16'h0053) begin errs++; $display("FAIL ena done result got %h want 0053", result); end
    ena = 1'b1;
    tick;
    out_ready = 1'b0;
    vectors++; if (out_valid !== 1'b0) begin errs++; $display("FAIL ena release out_valid got %b want 0", out_valid); end
  endtask
  task automatic test_reset_mid_mul;
    logic stray = 1'b0;
    op = 3'd2; a = 8'd3; b = 8'd5; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick;
    rst_n = 1'b0;
    tick; tick;
    vectors++; if (out_valid !== 1'b0) begin errs++; $display("FAIL rst_mul out_valid got %b want 0", out_valid); end
    vectors++; if (result !== 16'h0000) begin errs++; $display("FAIL rst_mul result got %h want 0000", result); end
    vectors++; if (flags !== 4'b0000) begin errs++; $display("FAIL rst_mul flags got %b want 0000", flags); end
    rst_n = 1'b1;
    tick;
    vectors++; if (in_ready !== 1'b1) begin errs++; $display("FAIL rst_mul in_ready got %b want 1", in_ready); end
    for (int i = 0; i < 12; i++) begin stray |= out_valid; tick; end
    vectors++; if (stray !== 1'b0) begin errs++; $display("FAIL rst_mul stray out_valid got %b want 0", stray); end
  endtask
  initial begin
    rst_n = 1'b0; ena = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    op = '0; a = '0; b = '0;
    tick; tick;
    rst_n = 1'b1;
    test_reset;
    test_single_cycle;
    test_mul;
    test_divide;
    test_back_to_back;
    test_ena;
    test_reset_mid_mul;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
